shared_reg_read_arbiter: RTL and testbench
==========================================

// Module: shared_reg_read_arbiter
// PURPOSE
//  Read side of the shared register/data-memory path in the multicore processor.
//  Up to CORES cores request reads of a shared single-read-port register bank.
//  The block arbitrates the requests round-robin and drives one synchronous read (1-cycle latency).
//  It then returns the data to the winning core with a one-cycle acknowledge.
// PARAMETERS
//  WIDTH       12  data width of the register bank
//  ADDR_WIDTH  8   register bank address width
//  CORES       4   number of requesting cores (>=2)
// PORTS
//  clk      in   1                 clock, all logic on rising edge
//  rst      in   1                 asynchronous, active-high reset
//  rdReq    in   CORES             per-core read request; held high until that core's rdAck
//  rdAddr   in   CORES*ADDR_WIDTH  core i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  rdAck    out  CORES             one-hot, one-cycle pulse: rdData is valid for that core
//  rdData   out  WIDTH             read data, broadcast to all cores, valid while rdAck!=0
//  memRdEn  out  1                 read strobe to the register bank, one-cycle pulse
//  memAddr  out  ADDR_WIDTH        bank address, valid while memRdEn=1
//  memData  in   WIDTH             bank output, valid from the edge after memRdEn and held
//  busy     out  1                 1 whenever state != IDLE
// BEHAVIOUR
//  Reset values: rdAck=0, rdData=0, memRdEn=0, memAddr=0, busy=0, state=IDLE, lastGrant=CORES-1.
//  All outputs are registered except busy, which is decoded from state.
//  FSM: IDLE -> READ -> WAIT -> ACK -> IDLE. One read is in flight at a time.
//  IDLE:
//   - On edge E0 with rdReq!=0, pick the winner g = first set bit searching lastGrant+1, +2, ... (mod CORES).
//   - Register g, set memAddr=rdAddr[g], set memRdEn=1, then go to READ.
//   - With no request, stay in IDLE.
//  READ:
//   - At E1, clear memRdEn; the bank samples the strobe at this edge.
//   - Go to WAIT.
//  WAIT:
//   - At E2, set rdData=memData and rdAck=(1<<g), update lastGrant=g, then go to ACK.
//  ACK:
//   - At E3, clear rdAck (rdData holds its value) and return to IDLE.
//   - rdReq is not sampled in ACK.
//  Latency and throughput:
//   - rdAck is high in the cycle after E2, i.e. 3 cycles after the request is sampled.
//   - One read every 4 cycles under continuous load.
//  Requester contract: drop rdReq in its rdAck cycle. A request still high at the next IDLE edge is a new read.
//  The address is captured at grant. Later changes to rdAddr[g] are ignored for this read.
//  If rdReq[g] drops after grant, the read still completes and rdAck[g] still pulses; there is no cancel.
//  Requests from non-granted cores wait without loss; no core waits more than CORES-1 grants.
//  memData is sampled only in WAIT. Values on it at other times are ignored.
//  rst in any state: immediately return to reset values. An in-flight read is dropped with no rdAck.
//  rdData is zeroed and core 0 gets first priority again.
//  Undefined (X) rdReq bits are not required to be handled; the bench drives known values.
// TESTING
//  1 Reset: assert rst during WAIT -> all outputs 0 immediately, no rdAck. After release, a core 3 request is served normally.
//  2 Single read: core 2 reads 8'h15, bank returns 12'hABC.
//    -> memRdEn=1 with memAddr=8'h15 for exactly one cycle.
//    -> rdAck=4'b0100 with rdData=12'hABC, 3 cycles after the sampling edge.
//  3 All four cores request together, each held until acked -> acks in order 0,1,2,3, spaced 4 cycles apart.
//  4 Fairness: cores 0 and 3 re-request immediately after each ack -> grants alternate 0,3,0,3. Neither core is starved.
//  5 Withdraw/address change: core 1 drops rdReq and changes rdAddr in READ.
//    -> memAddr keeps the original address and rdAck[1] still pulses once.
//  6 Idle stability: rdReq=0 for 10 cycles -> memRdEn=0, rdAck=0, busy=0 throughout, and rdData holds its last value.

Source files
------------

// File: rtl/shared_reg_read_arbiter.sv
// rtl/shared_reg_read_arbiter.sv - round-robin read arbiter for a shared single-port register bank
module shared_reg_read_arbiter #(
  parameter int WIDTH      = 12,
  parameter int ADDR_WIDTH = 8,
  parameter int CORES      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CORES-1:0]            rdReq,
  input  logic [CORES*ADDR_WIDTH-1:0] rdAddr,
  output logic [CORES-1:0]            rdAck,
  output logic [WIDTH-1:0]            rdData,
  output logic                        memRdEn,
  output logic [ADDR_WIDTH-1:0]       memAddr,
  input  logic [WIDTH-1:0]            memData,
  output logic                        busy
);

  localparam int GW = (CORES > 1) ? $clog2(CORES) : 1;

  typedef enum logic [1:0] {IDLE, READ, WAIT, ACK} state_t;

  state_t                state;
  logic [GW-1:0]         grant;
  logic [GW-1:0]         last_grant;
  logic [GW-1:0]         winner;
  logic                  found;
  logic [ADDR_WIDTH-1:0] addr_arr [CORES];

  for (genvar i = 0; i < CORES; i++) begin : g_addr
    assign addr_arr[i] = rdAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Search starts one past the previous winner, so every waiting core is reached within CORES-1 grants.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= CORES; k++) begin
      int idx;
      idx = int'(last_grant) + k;
      if (idx >= CORES) idx = idx - CORES;
      if (!found && rdReq[GW'(idx)]) begin
        winner = GW'(idx);
        found  = 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(CORES - 1);
      rdAck      <= '0;
      rdData     <= '0;
      memRdEn    <= 1'b0;
      memAddr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|rdReq) begin
            grant   <= winner;
            memAddr <= addr_arr[winner];
            memRdEn <= 1'b1;
            state   <= READ;
          end
        end
        READ: begin
          memRdEn <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          rdData       <= memData;
          rdAck        <= '0;
          rdAck[grant] <= 1'b1;
          last_grant   <= grant;
          state        <= ACK;
        end
        ACK: begin
          rdAck <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_reg_read_arbiter.sv
// tb/tb_shared_reg_read_arbiter.sv - scoreboard bench for shared_reg_read_arbiter
module tb_shared_reg_read_arbiter;

  localparam int W  = 12;
  localparam int AW = 8;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  rdReq;
  logic [N*AW-1:0] rdAddr;
  logic [N-1:0]  rdAck;
  logic [W-1:0]  rdData;
  logic          memRdEn;
  logic [AW-1:0] memAddr;
  logic [W-1:0]  memData;
  logic          busy;

  shared_reg_read_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .CORES(N)) dut (
    .clk(clk), .rst(rst), .rdReq(rdReq), .rdAddr(rdAddr), .rdAck(rdAck),
    .rdData(rdData), .memRdEn(memRdEn), .memAddr(memAddr), .memData(memData), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            core;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    int            cyc;
  } exp_t;

  logic [W-1:0]  mem [256];
  exp_t          ack_q[$];
  exp_t          adr_q[$];
  int            model_last = N - 1;
  int            next_free  = 0;
  int            busy_lo    = 1;
  int            busy_hi    = 0;
  int            passed     = 0;
  int            total      = 0;
  int            ack_cnt [N];
  logic [W-1:0]  last_data  = '0;
  logic [N-1:0]  pend_rr    = '0;
  logic          bank_pend  = 1'b0;
  logic [AW-1:0] bank_addr  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: predicts the read launched at the next rising edge from the round-robin rule.
  always @(negedge clk) begin
    if (!rst && cyc + 1 >= next_free && rdReq != 0) begin
      exp_t e;
      int   g;
      g = -1;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (model_last + k) % N;
        if (g < 0 && rdReq[idx]) g = idx;
      end
      e.core = g;
      e.addr = rdAddr[g*AW +: AW];
      e.data = mem[e.addr];
      e.cyc  = cyc + 1;
      adr_q.push_back(e);
      e.cyc  = cyc + 3;
      ack_q.push_back(e);
      model_last = g;
      next_free  = cyc + 5;
      busy_lo    = cyc + 1;
      busy_hi    = cyc + 3;
    end
  end

  // Register bank: responds to the strobe one edge later and holds; garbage while the arbiter is idle.
  always @(negedge clk) begin
    bank_pend <= memRdEn;
    bank_addr <= memAddr;
  end

  initial begin
    memData = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bank_pend) memData = mem[bank_addr];
      else if (!busy) memData = W'($urandom);
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      while (adr_q.size() != 0 && adr_q[0].cyc < cyc) begin
        e = adr_q.pop_front();
        check("memRdEn_missing", 0, 1);
      end
      if (memRdEn) begin
        if (adr_q.size() == 0) check("memRdEn_unexpected", 1, 0);
        else begin
          e = adr_q.pop_front();
          check("memRdEn_cycle", 64'(cyc), 64'(e.cyc));
          check("memAddr", memAddr, e.addr);
        end
      end
      while (ack_q.size() != 0 && ack_q[0].cyc < cyc) begin
        e = ack_q.pop_front();
        check("rdAck_missing", 0, 1);
      end
      if (rdAck != 0) begin
        for (int i = 0; i < N; i++) if (rdAck[i]) ack_cnt[i]++;
        if (ack_q.size() == 0) check("rdAck_unexpected", 64'(rdAck), 0);
        else begin
          e = ack_q.pop_front();
          check("rdAck_onehot", rdAck, N'(1) << e.core);
          check("rdAck_cycle", 64'(cyc), 64'(e.cyc));
          check("rdData", rdData, e.data);
          last_data = e.data;
        end
      end else begin
        check("rdData_hold", rdData, last_data);
      end
      check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
    end
  end

  task automatic step(input int prob, input logic [N-1:0] rereq);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rdAck[i]) begin
        rdReq[i] = 1'b0;
        if (rereq[i]) pend_rr[i] = 1'b1;
      end else if (!rdReq[i] && (pend_rr[i] || (prob > 0 && $urandom_range(99) < prob))) begin
        rdReq[i]            = 1'b1;
        pend_rr[i]          = 1'b0;
        rdAddr[i*AW +: AW]  = AW'($urandom);
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    pend_rr = '0;
    while ((rdReq != 0 || ack_q.size() != 0 || cyc < next_free - 1) && n < 60) begin
      step(0, '0);
      n++;
    end
    check(name, n < 60, 1);
  endtask

  task automatic do_reset();
    rdReq = '0;
    rst   = 1'b1;
    #1;
    check("rst_rdAck", rdAck, 0);
    check("rst_rdData", rdData, 0);
    check("rst_memRdEn", memRdEn, 0);
    check("rst_memAddr", memAddr, 0);
    check("rst_busy", busy, 0);
    ack_q.delete();
    adr_q.delete();
    model_last = N - 1;
    next_free  = 0;
    busy_lo    = 1;
    busy_hi    = 0;
    last_data  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int a1;
    rst    = 1'b1;
    rdReq  = '0;
    rdAddr = '0;
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    for (int i = 0; i < 256; i++) mem[i] = W'($urandom);
    mem[8'h15] = 12'hABC;
    @(posedge clk);
    #1;
    do_reset();

    // Reset while a read sits in WAIT: dropped without ack, then core 3 is served normally.
    rdReq[0] = 1'b1;
    rdAddr[0 +: AW] = 8'h40;
    @(posedge clk);
    #1;
    check("t1_granted", memRdEn, 1);
    @(posedge clk);
    #1;
    check("t1_in_wait", busy, 1);
    do_reset();
    rdReq[3] = 1'b1;
    rdAddr[3*AW +: AW] = 8'h77;
    wait_idle("t1_core3_done");
    check("t1_no_ack_core0", 64'(ack_cnt[0]), 0);
    check("t1_ack_core3", 64'(ack_cnt[3]), 1);

    // All four cores at once after reset-style priority (last grant = core 3).
    do_reset();
    rdReq = '1;
    for (int i = 0; i < N; i++) rdAddr[i*AW +: AW] = AW'(8'h10 + i);
    wait_idle("t3_all_done");

    // Single read: core 2, address 8'h15, bank value 12'hABC.
    rdReq[2] = 1'b1;
    rdAddr[2*AW +: AW] = 8'h15;
    wait_idle("t2_done");
    check("t2_data", rdData, 12'hABC);

    // Fairness: cores 0 and 3 re-request right after each ack.
    a1 = ack_cnt[0] - ack_cnt[3];
    rdReq[0] = 1'b1;
    rdReq[3] = 1'b1;
    for (int i = 0; i < 40; i++) step(0, 4'b1001);
    wait_idle("t4_done");
    check("t4_balance", ((ack_cnt[0] - ack_cnt[3]) - a1) inside {-1, 0, 1}, 1);

    // Withdraw and change address right after grant.
    a1 = ack_cnt[1];
    rdReq[1] = 1'b1;
    rdAddr[1*AW +: AW] = 8'h5A;
    @(posedge clk);
    #1;
    rdReq[1] = 1'b0;
    rdAddr[1*AW +: AW] = 8'hA5;
    wait_idle("t5_done");
    check("t5_one_ack", 64'(ack_cnt[1] - a1), 1);

    // Idle stability.
    for (int i = 0; i < 10; i++) begin
      step(0, '0);
      check("t6_memRdEn", memRdEn, 0);
      check("t6_rdAck", rdAck, 0);
      check("t6_busy", busy, 0);
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) step(30, '0);
    wait_idle("rand_done");
    check("adr_q_empty", 64'(adr_q.size()), 0);
    check("ack_q_empty", 64'(ack_q.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
